id_ex_stage: RTL and testbench

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush. It carries the decoded control bundle, NUM_OPS operand words and NUM_REGS register specifiers from decode to execute. Stalls are absorbed without a combinational ready path, and a flush turns every in-flight entry into a bubble whose control bits read zero. It supersedes the fixed-width, always-loading ID/EX register.

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register. It has a valid/ready handshake, a
//               2-entry skid buffer, a registered in_ready and a synchronous
//               flush. Invalid entries present a zero control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CTRL_W   = 10,
  parameter int DATA_W   = 32,
  parameter int NUM_OPS  = 3,
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0]    in_data,
  input  logic [NUM_REGS*REG_W-1:0]    in_regs,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0]    out_data,
  output logic [NUM_REGS*REG_W-1:0]    out_regs
);

  localparam int c_OPS_W  = NUM_OPS * DATA_W;
  localparam int c_REGS_W = NUM_REGS * REG_W;

  logic                r_main_valid;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [c_OPS_W-1:0]  r_main_data;
  logic [c_REGS_W-1:0] r_main_regs;

  logic                r_skid_valid;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [c_OPS_W-1:0]  r_skid_data;
  logic [c_REGS_W-1:0] r_skid_regs;

  logic                r_in_ready;

  logic                w_in_fire;
  logic                w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready & ~flush;
  assign w_out_fire = r_main_valid & out_ready;

  // The main/skid valid pair encodes the state: 00 EMPTY, 10 ONE, 11 FULL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_main_regs  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_regs  <= '0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case ({r_main_valid, r_skid_valid})
        2'b00: begin
          if (w_in_fire) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= in_ctrl;
            r_main_data  <= in_data;
            r_main_regs  <= in_regs;
          end
          r_in_ready <= 1'b1;
        end
        2'b10: begin
          if (w_in_fire && w_out_fire) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_main_regs <= in_regs;
          end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl;
            r_skid_data  <= in_data;
            r_skid_regs  <= in_regs;
            r_in_ready   <= 1'b0;
          end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (w_out_fire) begin
            r_main_ctrl  <= r_skid_ctrl;
            r_main_data  <= r_skid_data;
            r_main_regs  <= r_skid_regs;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
          end
        end
        default: begin
          // Skid valid without main valid is unreachable; recover to EMPTY.
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign out_regs  = r_main_regs;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Directed self-checking bench for id_ex_stage (default and reduced parameter sets).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_ctrl;
  logic [95:0] in_data;
  logic [14:0] in_regs;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_ctrl;
  logic [95:0] out_data;
  logic [14:0] out_regs;

  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [3:0]  p_in_ctrl;
  logic [15:0] p_in_data;
  logic [2:0]  p_in_regs;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [3:0]  p_out_ctrl;
  logic [15:0] p_out_data;
  logic [2:0]  p_out_regs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_regs(out_regs)
  );

  id_ex_stage #(.CTRL_W(4), .DATA_W(8), .NUM_OPS(2), .REG_W(3), .NUM_REGS(1)) dut_p (
    .clk(clk), .rst(rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_ctrl(p_in_ctrl), .in_data(p_in_data), .in_regs(p_in_regs),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_ctrl(p_out_ctrl), .out_data(p_out_data), .out_regs(p_out_regs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [9:0] c, input logic [31:0] d1);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {32'hCAFE_0000 | 32'(c), 32'h0, d1};
    in_regs  = {5'd3, 5'd2, c[4:0]};
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(1'b1, 10'h3FF, 32'hFFFF_FFFF);
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %h want 000", out_ctrl); end
    n_checks++; if (out_data !== 96'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_regs !== 15'h0) begin n_fail++; $display("FAIL reset_out_regs got %h want 0", out_regs); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    offer(1'b0, 10'h0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid cyc %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready beat %0d got %b want 1", i, in_ready); end
      offer(1'b1, 10'(i), 32'h100 + 32'(i));
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 10'(i)) begin n_fail++; $display("FAIL stream_ctrl beat %0d got v=%b c=%h want v=1 c=%h", i, out_valid, out_ctrl, 10'(i)); end
      n_checks++; if (out_data[31:0] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL stream_d1 beat %0d got %h want %h", i, out_data[31:0], 32'h100 + 32'(i)); end
    end
    n_checks++; if (out_data[95:64] !== 32'hCAFE_0008 || out_regs !== {5'd3, 5'd2, 5'd8}) begin n_fail++; $display("FAIL stream_op2_regs got %h/%h want cafe0008/%h", out_data[95:64], out_regs, {5'd3, 5'd2, 5'd8}); end
    offer(1'b0, 10'h0, 32'h0);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h0) begin n_fail++; $display("FAIL stream_drain got v=%b c=%h want v=0 c=000", out_valid, out_ctrl); end
    n_checks++; if (out_data[31:0] !== 32'h108) begin n_fail++; $display("FAIL stream_hold_data got %h want 108", out_data[31:0]); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    offer(1'b1, 10'd5, 32'd5);
    tick();
    n_checks++; if (out_ctrl !== 10'd5 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_A got c=%h rdy=%b want c=005 rdy=1", out_ctrl, in_ready); end
    offer(1'b1, 10'd6, 32'd6);
    tick();
    n_checks++; if (out_ctrl !== 10'd5 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got c=%h rdy=%b want c=005 rdy=0", out_ctrl, in_ready); end
    offer(1'b1, 10'd7, 32'd7);
    tick();
    n_checks++; if (out_ctrl !== 10'd5 || in_ready !== 1'b0 || out_data[31:0] !== 32'd5) begin n_fail++; $display("FAIL stall_hold got c=%h rdy=%b d=%h want c=005 rdy=0 d=5", out_ctrl, in_ready, out_data[31:0]); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_ctrl !== 10'd6 || in_ready !== 1'b1) begin n_fail++; $display("FAIL resume_B got c=%h rdy=%b want c=006 rdy=1", out_ctrl, in_ready); end
    tick();
    n_checks++; if (out_ctrl !== 10'd7 || out_data[31:0] !== 32'd7) begin n_fail++; $display("FAIL resume_C got c=%h d=%h want c=007 d=7", out_ctrl, out_data[31:0]); end
    offer(1'b0, 10'h0, 32'h0);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resume_empty got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    offer(1'b1, 10'h21, 32'h21);
    tick();
    offer(1'b1, 10'h22, 32'h22);
    tick();
    n_checks++; if (out_ctrl !== 10'h21 || in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefull got c=%h rdy=%b want c=021 rdy=0", out_ctrl, in_ready); end
    flush = 1'b1;
    offer(1'b1, 10'h23, 32'h23);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%b c=%h rdy=%b want v=0 c=000 rdy=1", out_valid, out_ctrl, in_ready); end
    flush = 1'b0;
    offer(1'b0, 10'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h0) begin n_fail++; $display("FAIL flush_no_ghost cyc %0d got v=%b c=%h want v=0 c=000", i, out_valid, out_ctrl); end
    end
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b1;
    offer(1'b1, 10'h11, 32'h11);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 10'h11) begin n_fail++; $display("FAIL ffire_one got v=%b c=%h want v=1 c=011", out_valid, out_ctrl); end
    offer(1'b0, 10'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ffire_empty got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h0) begin n_fail++; $display("FAIL ffire_no_dup got v=%b c=%h want v=0 c=000", out_valid, out_ctrl); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    offer(1'b1, 10'h31, 32'h31);
    tick();
    offer(1'b1, 10'h32, 32'h32);
    tick();
    rst = 1'b0;
    offer(1'b1, 10'h33, 32'h33);
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 96'h0) begin n_fail++; $display("FAIL midrst got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, out_data); end
    rst = 1'b1;
    offer(1'b0, 10'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got v=%b want 0", out_valid); end
  endtask

  task automatic test_params();
    p_out_ready = 1'b1;
    p_in_valid  = 1'b1;
    p_in_ctrl   = 4'h9;
    p_in_data   = 16'hA55A;
    p_in_regs   = 3'b101;
    tick();
    n_checks++; if (p_out_valid !== 1'b1 || p_out_ctrl !== 4'h9) begin n_fail++; $display("FAIL param_ctrl got v=%b c=%h want v=1 c=9", p_out_valid, p_out_ctrl); end
    n_checks++; if (p_out_data !== 16'hA55A || p_out_regs !== 3'b101) begin n_fail++; $display("FAIL param_data got %h/%b want a55a/101", p_out_data, p_out_regs); end
    p_in_valid = 1'b0;
    tick();
    n_checks++; if (p_out_valid !== 1'b0 || p_out_ctrl !== 4'h0 || p_out_data !== 16'hA55A) begin n_fail++; $display("FAIL param_bubble got v=%b c=%h d=%h want v=0 c=0 d=a55a", p_out_valid, p_out_ctrl, p_out_data); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_regs = '0;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_ctrl = '0; p_in_data = '0;
    p_in_regs = '0; p_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush_full();
    test_flush_fire();
    test_reset_midstream();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
